// File: rtl/vend_change_engine.sv
// vend_change_engine
//   Accumulates quarter/dollar credit, vends one of NUM_SEL products at
//   per-product prices, and pays change (or a full refund on cancel) as a
//   serial coin stream over a valid/ready handshake. Money is in quarters.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   quarter_in     : one-cycle pulse, quarter inserted
//   dollar_in      : one-cycle pulse, dollar inserted
//   cancel         : refund request
//   selection      : 0 = none, k = product k
//   coin_ready     : dispenser accepts presented coin
//   credit         : current credit / remaining change during payout
//   vend           : one-cycle dispense pulse
//   vend_id        : product being vended (0 when vend=0)
//   coin_valid     : coin presented to dispenser
//   coin_is_dollar : presented coin is a dollar (1) or quarter (0)
//   coin_reject    : one-cycle pulse, inserted coin must be returned
//   busy           : not idle
module vend_change_engine #(
  parameter int unsigned                 CREDIT_W   = 4,
  parameter int unsigned                 MAX_CREDIT = 8,
  parameter int unsigned                 NUM_SEL    = 2,
  parameter int unsigned                 SEL_W      = 2,
  parameter int unsigned                 PRICE_W    = 4,
  parameter logic [NUM_SEL*PRICE_W-1:0]  PRICES     = {4'd6, 4'd4},
  parameter int unsigned                 DOLLAR_VAL = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                quarter_in,
  input  logic                dollar_in,
  input  logic                cancel,
  input  logic [SEL_W-1:0]    selection,
  input  logic                coin_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_id,
  output logic                coin_valid,
  output logic                coin_is_dollar,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    PAYOUT = 2'd2
  } state_e;

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam int unsigned CMP_W = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;

  localparam logic [SUM_W-1:0]    MAX_SUM    = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0]    DOLLAR_SUM = SUM_W'(DOLLAR_VAL);
  localparam logic [CREDIT_W-1:0] DOLLAR_CR  = CREDIT_W'(DOLLAR_VAL);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                coin_reject_q, coin_reject_d;

  // Coin acceptance: sum is one bit wider than credit so it cannot wrap.
  logic                coin_any;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits;

  assign coin_any  = quarter_in | dollar_in;
  assign coin_val  = dollar_in ? DOLLAR_SUM : SUM_W'(1);
  assign coin_sum  = {1'b0, credit_q} + coin_val;
  assign coin_fits = (coin_sum <= MAX_SUM);

  // Price lookup for the current selection; shift avoids variable part-selects.
  logic [PRICE_W-1:0]  price;
  logic                sel_valid;
  logic                afford;

  always_comb begin
    price     = '0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
      if (selection == SEL_W'(k + 1)) begin
        sel_valid = 1'b1;
        price     = PRICE_W'(PRICES >> (k * PRICE_W));
      end
    end
  end

  assign afford = (CMP_W'(credit_q) >= CMP_W'(price));

  // Payout: dollars first while at least a dollar remains.
  logic                pay_dollar;
  logic [CREDIT_W-1:0] pay_rem;

  assign pay_dollar = (credit_q >= DOLLAR_CR);
  assign pay_rem    = credit_q - (pay_dollar ? DOLLAR_CR : CREDIT_W'(1));

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    coin_reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (quarter_in && dollar_in) begin
          coin_reject_d = 1'b1;
        end else if (coin_any) begin
          // A coin always wins over cancel/selection in the same cycle.
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           coin_reject_d = 1'b1;
        end else if (cancel && (credit_q != '0)) begin
          state_d = PAYOUT;
        end else if (sel_valid && afford) begin
          credit_d  = credit_q - CREDIT_W'(price);
          vend_id_d = selection;
          state_d   = VEND;
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        state_d       = (credit_q == '0) ? IDLE : PAYOUT;
      end
      PAYOUT: begin
        coin_reject_d = coin_any;
        if (coin_ready) begin
          credit_d = pay_rem;
          if (pay_rem == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_id_q     <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_id_q     <= vend_id_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign credit         = credit_q;
  assign vend           = (state_q == VEND);
  assign vend_id        = (state_q == VEND) ? vend_id_q : '0;
  assign coin_valid     = (state_q == PAYOUT);
  assign coin_is_dollar = (state_q == PAYOUT) && pay_dollar;
  assign coin_reject    = coin_reject_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_vend_change_engine.sv
// Self-checking bench for vend_change_engine: directed scenarios followed by
// randomized stimulus, all compared against a transaction-level model that
// keeps credit as an integer and pending change as a queue of coins.
module tb_vend_change_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       quarter_in, dollar_in, cancel, coin_ready;
  logic [1:0] selection;
  logic [3:0] credit;
  logic       vend;
  logic [1:0] vend_id;
  logic       coin_valid, coin_is_dollar, coin_reject, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_change_engine #(
    .CREDIT_W   (4),
    .MAX_CREDIT (8),
    .NUM_SEL    (2),
    .SEL_W      (2),
    .PRICE_W    (4),
    .PRICES     ({4'd6, 4'd4}),
    .DOLLAR_VAL (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .quarter_in     (quarter_in),
    .dollar_in      (dollar_in),
    .cancel         (cancel),
    .selection      (selection),
    .coin_ready     (coin_ready),
    .credit         (credit),
    .vend           (vend),
    .vend_id        (vend_id),
    .coin_valid     (coin_valid),
    .coin_is_dollar (coin_is_dollar),
    .coin_reject    (coin_reject),
    .busy           (busy)
  );

  // ---------------- reference model ----------------
  int m_credit;
  bit m_vend;
  int m_vend_id;
  bit m_reject;
  bit coinq[$];   // 1 = dollar, 0 = quarter, in payout order

  function automatic int price_of(int sel);
    return (sel == 1) ? 4 : 6;
  endfunction

  function automatic bit m_busy();
    return m_vend || (coinq.size() > 0);
  endfunction

  function automatic void m_load_change();
    coinq.delete();
    for (int i = 0; i < m_credit / 4; i++) coinq.push_back(1'b1);
    for (int i = 0; i < m_credit % 4; i++) coinq.push_back(1'b0);
  endfunction

  function automatic void m_reset();
    m_credit = 0; m_vend = 0; m_vend_id = 0; m_reject = 0;
    coinq.delete();
  endfunction

  function automatic void m_edge(bit q, bit d, bit c, int sel, bit rdy);
    bit rej = 0;
    if (m_busy()) begin
      if (q || d) rej = 1;
      if (m_vend) m_vend = 0;
      else if (rdy) begin
        m_credit -= coinq[0] ? 4 : 1;
        void'(coinq.pop_front());
      end
    end else begin
      if (q && d) rej = 1;
      else if (q || d) begin
        int v = d ? 4 : 1;
        if (m_credit + v <= 8) m_credit += v;
        else rej = 1;
      end else if (c && m_credit != 0) begin
        m_load_change();
      end else if (sel >= 1 && sel <= 2 && m_credit >= price_of(sel)) begin
        m_credit -= price_of(sel);
        m_vend    = 1;
        m_vend_id = sel;
        m_load_change();
      end
    end
    m_reject = rej;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    bit cv = (coinq.size() > 0) && !m_vend;
    chk({tag, ".credit"},      32'(credit),        32'(m_credit));
    chk({tag, ".vend"},        32'(vend),          32'(m_vend));
    chk({tag, ".vend_id"},     32'(vend_id),       m_vend ? 32'(m_vend_id) : 32'd0);
    chk({tag, ".coin_valid"},  32'(coin_valid),    32'(cv));
    chk({tag, ".coin_dollar"}, 32'(coin_is_dollar), cv ? 32'(coinq[0]) : 32'd0);
    chk({tag, ".coin_reject"}, 32'(coin_reject),   32'(m_reject));
    chk({tag, ".busy"},        32'(busy),          32'(m_busy()));
  endtask

  task automatic step(string tag, bit q, bit d, bit c, int sel, bit rdy);
    quarter_in = q; dollar_in = d; cancel = c;
    selection  = 2'(sel); coin_ready = rdy;
    @(posedge clk);
    m_edge(q, d, c, sel, rdy);
    #1 check_all(tag);
  endtask

  task automatic idle1(string tag);
    step(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (m_busy() && n < 20) begin
      step(tag, 0, 0, 0, 0, 1);
      n++;
    end
    chk({tag, ".drained"}, 32'(busy), 32'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    #1 m_reset();
    chk({tag, ".credit0"}, 32'(credit),     32'd0);
    chk({tag, ".cv0"},     32'(coin_valid), 32'd0);
    chk({tag, ".busy0"},   32'(busy),       32'd0);
    check_all(tag);
    @(posedge clk);
    #1 check_all(tag);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; quarter_in = 0; dollar_in = 0; cancel = 0;
    selection = '0; coin_ready = 0;
    m_reset();
    #1 check_all("por");
    @(posedge clk);
    #1 check_all("por_edge");
    #2 reset = 1'b1;

    // Reset in the middle of a payout
    step("rp_d", 0, 1, 0, 0, 0);
    step("rp_q", 1, 0, 0, 0, 0);
    step("rp_cancel", 0, 0, 1, 0, 0);
    step("rp_stall", 0, 0, 0, 0, 0);
    chk("rp_credit5", 32'(credit), 32'd5);
    async_reset("rp_rst");
    step("rp_after_q", 1, 0, 0, 0, 0);
    chk("rp_after_credit", 32'(credit), 32'd1);
    step("rp_cancel2", 0, 0, 1, 0, 0);
    drain("rp_drain");

    // Q, Q, D = 6, buy product 1, change two quarters
    step("s2_q1", 1, 0, 0, 0, 0);
    step("s2_q2", 1, 0, 0, 0, 0);
    step("s2_d",  0, 1, 0, 0, 0);
    chk("s2_credit6", 32'(credit), 32'd6);
    step("s2_sel", 0, 0, 0, 1, 1);
    chk("s2_vend", 32'(vend), 32'd1);
    chk("s2_vend_id", 32'(vend_id), 32'd1);
    step("s2_pay0", 0, 0, 0, 0, 1);
    chk("s2_first_quarter", 32'(coin_is_dollar), 32'd0);
    drain("s2_drain");

    // D, D = 8, buy product 2 with a stalled dispenser
    step("s3_d1", 0, 1, 0, 0, 0);
    step("s3_d2", 0, 1, 0, 0, 0);
    step("s3_sel", 0, 0, 0, 2, 0);
    chk("s3_vend_id", 32'(vend_id), 32'd2);
    for (int i = 0; i < 4; i++) step("s3_stall", 0, 0, 0, 0, 0);
    chk("s3_stall_credit", 32'(credit), 32'd2);
    drain("s3_drain");

    // 8 credit, product 1: single dollar of change; coin during VEND rejected
    step("s4_d1", 0, 1, 0, 0, 0);
    step("s4_d2", 0, 1, 0, 0, 0);
    step("s4_sel", 0, 0, 0, 1, 0);
    step("s4_vend_coin", 1, 0, 0, 0, 0);
    chk("s4_dollar", 32'(coin_is_dollar), 32'd1);
    step("s4_pay_coin", 0, 1, 0, 0, 0);
    drain("s4_drain");

    // Overflow and simultaneous coins
    step("s5_d", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("s5_q", 1, 0, 0, 0, 0);
    step("s5_over", 0, 1, 0, 0, 0);
    chk("s5_over_rej", 32'(coin_reject), 32'd1);
    chk("s5_over_credit", 32'(credit), 32'd7);
    step("s5_both", 1, 1, 0, 0, 0);
    chk("s5_both_rej", 32'(coin_reject), 32'd1);
    step("s5_q8", 1, 0, 0, 0, 0);
    chk("s5_credit8", 32'(credit), 32'd8);
    step("s5_coin_vs_sel", 1, 0, 0, 1, 0);
    step("s5_cancel", 0, 0, 1, 0, 1);
    drain("s5_drain");

    // Cancel refund, insufficient credit, invalid selection, empty cancel
    step("s6_d", 0, 1, 0, 0, 0);
    step("s6_q", 1, 0, 0, 0, 0);
    step("s6_cancel", 0, 0, 1, 0, 1);
    chk("s6_refund_dollar", 32'(coin_is_dollar), 32'd1);
    drain("s6_drain");
    for (int i = 0; i < 3; i++) step("s6_q3", 1, 0, 0, 0, 0);
    step("s6_insuff", 0, 0, 0, 1, 0);
    chk("s6_insuff_busy", 32'(busy), 32'd0);
    step("s6_sel3", 0, 0, 0, 3, 0);
    step("s6_cancel3", 0, 0, 1, 0, 1);
    drain("s6_drain3");
    step("s6_cancel0", 0, 0, 1, 0, 0);
    chk("s6_cancel0_busy", 32'(busy), 32'd0);
    idle1("s6_idle");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0 && m_busy()) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(4) == 0,
             $urandom_range(7) == 0,
             $urandom_range(19) == 0,
             ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 0,
             $urandom_range(3) != 0);
      end
    end
    drain("rnd_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
